// File: rtl/sss_rd_seq.sv
// SSS reference table read sequencer: picks one stored sequence and streams
// it out as valid/ready samples with a last marker, absorbing backpressure.
module sss_rd_seq #(
   parameter int pDAT_W   = 4,
   parameter int pDAT_Num = 1024,
   parameter int pSEQ_LEN = 128
) (
   input  logic              iclk,
   input  logic              irst_n,
   input  logic              istart,
   input  logic [7:0]        iseq_idx,
   output logic              obusy,
   output logic              oerr,
   output logic              oram_val,
   output logic [10:0]       oram_addr,
   input  logic [pDAT_W-1:0] iram_dat,
   output logic              oval,
   output logic [pDAT_W-1:0] odat,
   output logic              olast,
   input  logic              iready,
   output logic              odone
);

   localparam int          pSEQ_NUM = pDAT_Num / pSEQ_LEN;
   localparam logic [11:0] SEQ_NUM  = 12'(pSEQ_NUM);
   localparam logic [10:0] LEN      = 11'(pSEQ_LEN);
   localparam logic [10:0] CNT_LAST = 11'(pSEQ_LEN - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [10:0] base_q, base_d;
   logic [10:0] cnt_q, cnt_d;
   logic        oval_q, olast_q, oerr_q, odone_q;
   logic        issue, accept, last_issue;
   logic        start_bad, done_d;

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      issue     = 1'b0;
      start_bad = 1'b0;
      done_d    = 1'b0;
      accept    = oval_q && iready;
      unique case (state_q)
         IDLE: begin
            if (istart) begin
               if ({4'b0, iseq_idx} < SEQ_NUM) begin
                  base_d  = {3'b0, iseq_idx} * LEN;
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  start_bad = 1'b1;
               end
            end
         end
         RUN: begin
            // a read is only issued when the output register can take it
            issue = !oval_q || iready;
            if (issue) begin
               cnt_d = cnt_q + 11'd1;
               if (cnt_q == CNT_LAST)
                  state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (accept && olast_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      last_issue = issue && (cnt_q == CNT_LAST);
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         oval_q  <= 1'b0;
         olast_q <= 1'b0;
         oerr_q  <= 1'b0;
         odone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         oerr_q  <= start_bad;
         odone_q <= done_d;
         if (issue) begin
            oval_q  <= 1'b1;
            olast_q <= last_issue;
         end else if (accept) begin
            oval_q  <= 1'b0;
            olast_q <= 1'b0;
         end
      end
   end

   assign obusy     = (state_q != IDLE);
   assign oerr      = oerr_q;
   assign oram_val  = issue;
   assign oram_addr = (state_q == RUN) ? base_q + cnt_q : '0;
   assign oval      = oval_q;
   assign odat      = iram_dat;
   assign olast     = olast_q;
   assign odone     = odone_q;

endmodule

// File: tb/tb_sss_rd_seq.sv
// Bench for sss_rd_seq: behavioural table/stream model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sss_rd_seq;

   localparam int W   = 4;
   localparam int N   = 1024;
   localparam int L   = 128;
   localparam int NUM = N / L;

   logic          iclk = 1'b0;
   logic          irst_n = 1'b0;
   logic          istart = 1'b0;
   logic [7:0]    iseq_idx = '0;
   logic          iready = 1'b1;
   logic [W-1:0]  iram_dat = '0;
   logic          obusy, oerr, oram_val, oval, olast, odone;
   logic [10:0]   oram_addr;
   logic [W-1:0]  odat;

   sss_rd_seq #(.pDAT_W(W), .pDAT_Num(N), .pSEQ_LEN(L)) dut (
      .iclk(iclk), .irst_n(irst_n), .istart(istart),
      .iseq_idx(iseq_idx), .obusy(obusy), .oerr(oerr),
      .oram_val(oram_val), .oram_addr(oram_addr),
      .iram_dat(iram_dat), .oval(oval), .odat(odat),
      .olast(olast), .iready(iready), .odone(odone)
   );

   always #5 iclk = ~iclk;

   logic [W-1:0] mem [N];

   always @(posedge iclk)
      if (oram_val) iram_dat <= mem[oram_addr];

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // sequence-level model: what is busy, what sample is held, what is next
   bit m_busy, m_hv, m_err, m_done;
   int m_base, m_next, m_hidx;
   bit iss, acc, was_busy;

   always @(negedge iclk) begin
      if (!irst_n) begin
         m_busy = 0; m_hv = 0; m_err = 0; m_done = 0;
         m_base = 0; m_next = 0; m_hidx = 0;
         chk("rst_outs", {obusy, oerr, oram_val, oval, olast, odone,
                          oram_addr}, 0);
      end else begin
         iss = m_busy && (m_next < L) && (!m_hv || iready);
         chk("obusy", obusy, m_busy);
         chk("oerr", oerr, m_err);
         chk("odone", odone, m_done);
         chk("oval", oval, m_hv);
         chk("oram_val", oram_val, iss);
         if (iss) chk("oram_addr", oram_addr, m_base + m_next);
         if (m_hv) begin
            chk("odat", odat, mem[m_base + m_hidx]);
            chk("olast", olast, m_hidx == L - 1);
         end
         acc = m_hv && iready;
         was_busy = m_busy;
         m_err = !was_busy && istart && (iseq_idx >= NUM);
         m_done = acc && (m_hidx == L - 1);
         if (iss) begin
            m_hv = 1; m_hidx = m_next; m_next++;
         end else if (acc) begin
            m_hv = 0;
         end
         if (m_done) m_busy = 0;
         if (!was_busy && istart && (iseq_idx < NUM)) begin
            m_busy = 1; m_base = iseq_idx * L; m_next = 0;
         end
      end
   end

   int r_first, r_done1, r_done2, r_samp, r_last;
   int r_ndone, r_err, r_busy, r_val;

   task automatic go(input int idx, input bit rnd, input int chain,
                     input int intr, input int rst_at, input int want);
      int cyc;
      r_first = -1; r_done1 = -1; r_done2 = -1; r_samp = 0;
      r_last = 0; r_ndone = 0; r_err = 0; r_busy = 0; r_val = 0;
      istart = 1'b1;
      iseq_idx = 8'(idx);
      cyc = 0;
      forever begin
         @(posedge iclk);
         #1;
         cyc++;
         istart = 1'b0;
         iready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (cyc == 5 && intr >= 0) begin
            istart = 1'b1; iseq_idx = 8'(intr);
         end
         if (odone) begin
            r_ndone++;
            if (r_ndone == 1) r_done1 = cyc;
            else r_done2 = cyc;
            if (chain >= 0 && r_ndone == 1) begin
               istart = 1'b1; iseq_idx = 8'(chain);
            end
         end
         #1;
         if (cyc == 1) r_first = oram_addr;
         if (oerr) r_err++;
         if (obusy) r_busy++;
         if (oram_val) r_val++;
         if (oval && iready) begin
            r_samp++;
            if (olast) r_last++;
         end
         if (rst_at > 0 && r_samp == rst_at) begin
            irst_n = 1'b0;
            break;
         end
         if (r_ndone >= want && cyc >= 12) break;
         if (cyc > 3000) begin
            chk("timeout", cyc, 0);
            break;
         end
      end
      istart = 1'b0;
   endtask

   initial begin
      int idx;
      for (int i = 0; i < N; i++) mem[i] = W'($urandom);
      repeat (3) @(posedge iclk);
      #1 irst_n = 1'b1;
      @(posedge iclk);
      #1;

      go(3, 0, -1, -1, 0, 1);
      chk("t1_first_addr", r_first, 384);
      chk("t1_done_cyc", r_done1, 130);
      chk("t1_samples", r_samp, 128);
      chk("t1_lasts", r_last, 1);

      go(3, 1, -1, -1, 0, 1);
      chk("t2_first_addr", r_first, 384);
      chk("t2_samples", r_samp, 128);
      chk("t2_lasts", r_last, 1);

      go(8, 0, -1, -1, 0, 0);
      chk("t3_err_pulses", r_err, 1);
      chk("t3_busy_cycles", r_busy, 0);
      chk("t3_ram_vals", r_val, 0);

      go(2, 1, -1, 5, 0, 1);
      chk("t4_first_addr", r_first, 256);
      chk("t4_samples", r_samp, 128);
      chk("t4_err_pulses", r_err, 0);
      chk("t4_dones", r_ndone, 1);

      go(4, 1, -1, -1, 40, 1);
      #1;
      chk("t5_rst_outs", {obusy, oerr, oram_val, oval, olast, odone,
                          oram_addr}, 0);
      repeat (2) @(posedge iclk);
      #1 irst_n = 1'b1;
      @(posedge iclk);
      #1;
      go(0, 0, -1, -1, 0, 1);
      chk("t5_first_addr", r_first, 0);
      chk("t5_samples", r_samp, 128);
      chk("t5_done_cyc", r_done1, 130);

      go(7, 0, 0, -1, 0, 2);
      chk("t6_first_addr", r_first, 896);
      chk("t6_samples", r_samp, 256);
      chk("t6_lasts", r_last, 2);
      chk("t6_dones", r_ndone, 2);
      chk("t6_gap", r_done2 - r_done1, 130);

      repeat (6) begin
         idx = $urandom_range(0, 9);
         go(idx, 1, -1, -1, 0, (idx < NUM) ? 1 : 0);
         chk("rnd_samples", r_samp, (idx < NUM) ? 128 : 0);
         chk("rnd_err", r_err, (idx < NUM) ? 0 : 1);
      end

      repeat (4) @(posedge iclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
